gpu_dot_scheduler: RTL and testbench

Job scheduler that owns one `gpu_top` pipeline and shares it among `NUM_REQ` requesters using round-robin arbitration. A granted job is a dot product of `len` elements starting at `base_addr`. The scheduler issues one `gpu_top` start per element, accumulates the per-element results, counts zero-skips and reports completion to the owning requester. It sits between the requester logic and `gpu_top`, which it drives through `gpu_top`'s `start`, `weight_addr`, `activation_in`, `result_out`, `valid_out` and `zero_skipped` ports.

---
 rtl/gpu_dot_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_gpu_dot_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_dot_scheduler.sv
// Round-robin job scheduler that shares one gpu_top pipeline among NUM_REQ requesters.
// Each job issues one gpu_top start per element and accumulates the results into a dot product.
module gpu_dot_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ACC_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] base_addr,
    input  logic [5*NUM_REQ-1:0] len,
    input  logic [8*NUM_REQ-1:0] act_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [3:0]           act_idx,
    output logic [NUM_REQ-1:0]   done,
    output logic [ACC_W-1:0]     job_result,
    output logic [4:0]           zero_count,
    output logic                 job_err,
    output logic                 acc_ovf,
    output logic                 gpu_start,
    output logic [3:0]           gpu_weight_addr,
    output logic [7:0]           gpu_activation,
    input  logic [63:0]          gpu_result,
    input  logic                 gpu_valid,
    input  logic                 gpu_zero_skipped
);

    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [3:0]         base_q, base_d;
    logic [4:0]         len_q, len_d;
    logic [3:0]         act_idx_q, act_idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [4:0]         zero_cnt_q, zero_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]         waddr_q, waddr_d;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   probe;
    logic [3:0]         cap_base;
    logic [4:0]         cap_len;
    logic [ACC_W:0]     sum;
    logic               last_elem;
    logic               is_resp;

    // First pending requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        probe = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req[probe]) begin
                found = 1'b1;
                pick  = probe;
            end
        end
    end

    always_comb begin
        cap_base = '0;
        cap_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                cap_base = base_addr[4*i +: 4];
                cap_len  = len[5*i +: 5];
            end
        end
    end

    always_comb begin
        gpu_activation = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) gpu_activation = act_data[8*i +: 8];
        end
    end

    assign sum       = {1'b0, acc_q} + {1'b0, gpu_result[ACC_W-1:0]};
    assign last_elem = ({1'b0, act_idx_q} == (len_q - 5'd1));

    // NOTE: every *_d defaults to its current value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        base_d     = base_q;
        len_d      = len_q;
        act_idx_d  = act_idx_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        zero_cnt_d = zero_cnt_q;
        tmo_d      = tmo_q;
        waddr_d    = waddr_q;
        unique case (state_q)
            // IDLE spends one cycle capturing the job (grant rises) and dispatches on the next.
            IDLE: begin
                if (grant_q == '0) begin
                    if (found) begin
                        grant_d    = NUM_REQ'(1) << pick;
                        base_d     = cap_base;
                        len_d      = cap_len;
                        act_idx_d  = '0;
                        acc_d      = '0;
                        ovf_d      = 1'b0;
                        err_d      = 1'b0;
                        zero_cnt_d = '0;
                        rr_ptr_d   = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    end
                end else begin
                    state_d = (len_q == 5'd0) ? RESP : ISSUE;
                    waddr_d = base_q + act_idx_q;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (gpu_valid) begin
                    acc_d      = sum[ACC_W-1:0];
                    ovf_d      = ovf_q | sum[ACC_W];
                    zero_cnt_d = zero_cnt_q + {4'd0, gpu_zero_skipped};
                    if (last_elem) begin
                        state_d = RESP;
                    end else begin
                        act_idx_d = act_idx_q + 4'd1;
                        waddr_d   = base_q + act_idx_d;
                        state_d   = ISSUE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of all others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            base_q     <= '0;
            len_q      <= '0;
            act_idx_q  <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            zero_cnt_q <= '0;
            tmo_q      <= '0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            base_q     <= base_d;
            len_q      <= len_d;
            act_idx_q  <= act_idx_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            zero_cnt_q <= zero_cnt_d;
            tmo_q      <= tmo_d;
            waddr_q    <= waddr_d;
        end
    end

    assign is_resp         = (state_q == RESP);
    assign grant           = grant_q;
    assign act_idx         = act_idx_q;
    assign gpu_start       = (state_q == ISSUE);
    assign gpu_weight_addr = waddr_q;
    assign done            = is_resp ? grant_q : '0;
    assign job_result      = is_resp ? acc_q : '0;
    assign zero_count      = is_resp ? zero_cnt_q : '0;
    assign job_err         = is_resp & err_q;
    assign acc_ovf         = is_resp & ovf_q;

    // Result bits above ACC_W are intentionally dropped.
    if (ACC_W < 64) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^gpu_result[63:ACC_W];
    end

endmodule

// File: tb/tb_gpu_dot_scheduler.sv
// Scoreboard bench for gpu_dot_scheduler with a behavioural gpu_top model
// (valid 4 cycles after start, result = addr * act).
module tb_gpu_dot_scheduler;

    localparam int NUM_REQ = 2;
    localparam int ACC_W   = 32;
    localparam int TIMEOUT = 64;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] base_addr;
    logic [5*NUM_REQ-1:0] len;
    logic [8*NUM_REQ-1:0] act_data;
    logic [NUM_REQ-1:0]   grant;
    logic [3:0]           act_idx;
    logic [NUM_REQ-1:0]   done;
    logic [ACC_W-1:0]     job_result;
    logic [4:0]           zero_count;
    logic                 job_err;
    logic                 acc_ovf;
    logic                 gpu_start;
    logic [3:0]           gpu_weight_addr;
    logic [7:0]           gpu_activation;
    logic [63:0]          gpu_result;
    logic                 gpu_valid;
    logic                 gpu_zero_skipped;

    gpu_dot_scheduler #(.NUM_REQ(NUM_REQ), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .base_addr(base_addr), .len(len),
        .act_data(act_data), .grant(grant), .act_idx(act_idx), .done(done),
        .job_result(job_result), .zero_count(zero_count), .job_err(job_err),
        .acc_ovf(acc_ovf), .gpu_start(gpu_start), .gpu_weight_addr(gpu_weight_addr),
        .gpu_activation(gpu_activation), .gpu_result(gpu_result), .gpu_valid(gpu_valid),
        .gpu_zero_skipped(gpu_zero_skipped)
    );

    typedef struct {
        logic [NUM_REQ-1:0] owner;
        logic [ACC_W-1:0]   res;
        logic [4:0]         zc;
        logic               err;
        logic               ovf;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] addr_q[$];
    exp_t       mon_e;

    logic [7:0] act_tab0 [16];
    logic [7:0] act_tab1 [16];
    assign act_data = {act_tab1[act_idx], act_tab0[act_idx]};

    int         tests = 0;
    int         fails = 0;
    int         total_starts = 0;
    int         job_starts = 0;
    int         late_req = 0;
    int         late_done = 0;
    logic       no_resp;
    logic [63:0] force_res;
    logic [63:0] pend_res;
    time        last_valid_t = 0;
    time        last_start_t = 0;
    int         cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push_job(input logic [NUM_REQ-1:0] owner, input logic [ACC_W-1:0] res,
                            input logic [4:0] zc, input logic err, input logic ovf);
        exp_t e;
        e.owner = owner; e.res = res; e.zc = zc; e.err = err; e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Raise req[r] with its job fields, then check grant one edge later and drop req.
    task automatic launch(input int r, input logic [3:0] b, input logic [4:0] l);
        logic [NUM_REQ-1:0] onehot;
        onehot = '0;
        onehot[r] = 1'b1;
        base_addr[4*r +: 4] = b;
        len[5*r +: 5] = l;
        req[r] = 1'b1;
        @(negedge clk);
        check("grant_latency", grant, onehot);
        req[r] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || grant != '0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            tests++;
            fails++;
            $display("FAIL %s_complete: grant=%b pending=%0d after 400 cycles, required completion",
                     name, grant, exp_q.size());
            exp_q.delete();
            addr_q.delete();
        end
    endtask

    // Behavioural gpu_top; shares rst_n with the scheduler.
    initial begin
        gpu_valid = 1'b0;
        gpu_result = '0;
        gpu_zero_skipped = 1'b0;
        pend_res = '0;
        forever begin
            @(negedge clk);
            gpu_valid = 1'b0;
            gpu_zero_skipped = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (grant == '0) job_starts = 0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        gpu_valid = 1'b1;
                        gpu_result = pend_res;
                        gpu_zero_skipped = (pend_res == 64'd0);
                        last_valid_t = $time;
                    end
                end else if (late_req != late_done) begin
                    late_done = late_req;
                    gpu_valid = 1'b1;
                    gpu_result = 64'd99;
                    last_valid_t = $time;
                end
                if (gpu_start) begin
                    total_starts++;
                    last_start_t = $time;
                    if (job_starts > 0) check("start_spacing_ns", $time - last_valid_t, 64'd10);
                    job_starts++;
                    if (addr_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_start: got start at addr %0d, required none", gpu_weight_addr);
                    end else begin
                        check("weight_addr", gpu_weight_addr, addr_q.pop_front());
                    end
                    pend_res = (force_res != 64'd0) ? force_res
                                                    : 64'(gpu_weight_addr) * 64'(gpu_activation);
                    if (!no_resp) cnt = 4;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=%b, required no completion", done);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_owner", done, mon_e.owner);
                    check("job_result", job_result, mon_e.res);
                    check("zero_count", zero_count, mon_e.zc);
                    check("job_err", job_err, mon_e.err);
                    check("acc_ovf", acc_ovf, mon_e.ovf);
                end
            end
        end
    end

    initial begin
        int s0;
        int n;
        int n_done;
        time t_done;
        rst_n = 1'b0;
        req = '0;
        base_addr = '0;
        len = '0;
        no_resp = 1'b0;
        force_res = '0;
        for (int i = 0; i < 16; i++) begin
            act_tab0[i] = '0;
            act_tab1[i] = '0;
        end

        repeat (2) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_gpu_start", gpu_start, 0);
        check("rst_act_idx", act_idx, 0);
        check("rst_weight_addr", gpu_weight_addr, 0);
        check("rst_job_result", job_result, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single job: addresses 2,3,4, sum 2+6+12.
        act_tab0[0] = 8'd1; act_tab0[1] = 8'd2; act_tab0[2] = 8'd3;
        addr_q.push_back(4'd2); addr_q.push_back(4'd3); addr_q.push_back(4'd4);
        push_job(2'b01, 32'd20, 5'd0, 1'b0, 1'b0);
        s0 = total_starts;
        launch(0, 4'd2, 5'd3);
        @(negedge clk);
        check("first_start_latency", gpu_start, 1);
        wait_idle("single");
        check("single_starts", total_starts - s0, 3);

        // Address wrap with zero products: 14,15,0,1.
        act_tab0[0] = 8'd1; act_tab0[1] = 8'd0; act_tab0[2] = 8'd1; act_tab0[3] = 8'd1;
        addr_q.push_back(4'd14); addr_q.push_back(4'd15); addr_q.push_back(4'd0); addr_q.push_back(4'd1);
        push_job(2'b01, 32'd15, 5'd2, 1'b0, 1'b0);
        launch(0, 4'd14, 5'd4);
        wait_idle("wrap");

        // len=0 on requester 1: done in the cycle after grant, no start.
        push_job(2'b10, 32'd0, 5'd0, 1'b0, 1'b0);
        s0 = total_starts;
        launch(1, 4'd7, 5'd0);
        @(negedge clk);
        check("len0_done_latency", done, 2'b10);
        wait_idle("len0");
        check("len0_starts", total_starts - s0, 0);

        // Round-robin with both requesters held: grants 0,1,0,1.
        act_tab0[0] = 8'd5;
        act_tab1[0] = 8'd2; act_tab1[1] = 8'd4;
        base_addr = {4'd3, 4'd1};
        len = {5'd2, 5'd1};
        for (int j = 0; j < 2; j++) begin
            addr_q.push_back(4'd1);
            addr_q.push_back(4'd3); addr_q.push_back(4'd4);
            push_job(2'b01, 32'd5, 5'd0, 1'b0, 1'b0);
            push_job(2'b10, 32'd22, 5'd0, 1'b0, 1'b0);
        end
        s0 = total_starts;
        req = 2'b11;
        n = 0;
        n_done = 0;
        while (n_done < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (done != '0) begin
                n_done++;
                if (n_done == 4) req = '0;
            end
        end
        req = '0;
        wait_idle("rr");
        check("rr_jobs", n_done, 4);
        check("rr_starts", total_starts - s0, 6);

        // Accumulator carry: 3 x 0x8000_0000 wraps to 0x8000_0000; bits above ACC_W ignored.
        force_res = 64'h0000_0001_8000_0000;
        addr_q.push_back(4'd0); addr_q.push_back(4'd1); addr_q.push_back(4'd2);
        push_job(2'b01, 32'h8000_0000, 5'd0, 1'b0, 1'b1);
        launch(0, 4'd0, 5'd3);
        wait_idle("ovf");
        force_res = '0;

        // Timeout: no gpu_valid ever; done with job_err TIMEOUT+1 cycles after start.
        no_resp = 1'b1;
        addr_q.push_back(4'd5);
        push_job(2'b01, 32'd0, 5'd0, 1'b1, 1'b0);
        s0 = total_starts;
        launch(0, 4'd5, 5'd3);
        n = 0;
        while (done == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        t_done = $time;
        check("timeout_done_seen", (done != '0), 1);
        check("timeout_latency", (t_done - last_start_t) / 10, TIMEOUT + 1);
        wait_idle("timeout");
        check("timeout_starts", total_starts - s0, 1);
        late_req++;
        repeat (6) @(negedge clk);
        check("late_valid_ignored", grant, 0);
        no_resp = 1'b0;

        // Reset during WAIT: outputs drop at once, no done, rr_ptr back to 0.
        act_tab0[0] = 8'd3; act_tab0[1] = 8'd3;
        addr_q.push_back(4'd9);
        launch(0, 4'd9, 5'd2);
        n = 0;
        while (!gpu_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midjob_started", gpu_start, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_done", done, 0);
        check("midrst_weight_addr", gpu_weight_addr, 0);
        check("midrst_activation", gpu_activation, 0);
        check("midrst_result_flags", {job_result, zero_count, job_err, acc_ovf, gpu_start}, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        addr_q.delete();
        @(negedge clk);
        act_tab0[0] = 8'd7;
        act_tab1[0] = 8'd1;
        base_addr = {4'd4, 4'd2};
        len = {5'd1, 5'd1};
        addr_q.push_back(4'd2);
        push_job(2'b01, 32'd14, 5'd0, 1'b0, 1'b0);
        req = 2'b11;
        @(negedge clk);
        check("post_reset_rr_ptr", grant, 2'b01);
        req = '0;
        wait_idle("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
